// File: rtl/shreg_seq_if.sv
// shreg_seq_if: command/status bundle between a requester and shreg_seq.
//   start     - command request (honoured only while the sequencer is idle)
//   dir       - 0 shift right, 1 shift left
//   mode      - fill mode: 00 zero, 01 one, 10 rotate, 11 arithmetic
//   amount    - number of shift cycles (0 = load only)
//   load_val  - value parallel-loaded before shifting
//   busy      - sequencer is in LOAD or SHIFT
//   done      - one-cycle completion pulse
//   remaining - shifts still to issue (0 outside SHIFT)
interface shreg_seq_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [CNT_W-1:0] amount;
    logic [3:0]       load_val;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, dir, mode, amount, load_val,
        input  busy, done, remaining
    );

    modport slave (
        input  start, dir, mode, amount, load_val,
        output busy, done, remaining
    );
endinterface

// File: rtl/shreg_seq.sv
// shreg_seq: sequencing controller for a 4-bit universal shift register.
// Accepts one command (value, direction, fill mode, count), then drives the
// register through one parallel load, N shifts and a one-cycle done pulse.
// Ports:
//   clk, clr   - clock and synchronous active-high reset (shared with register)
//   bus        - command/status interface (slave side)
//   q          - register data_out, used for rotate and sign-fill feedback
//   c          - register control: 00 hold, 01 right, 10 left, 11 load
//   data_in    - register parallel input
//   carry_msb  - serial input entering bit 3 on right shifts
//   carry_lsb  - serial input entering bit 0 on left shifts
module shreg_seq #(
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        clr,
    shreg_seq_if.slave  bus,
    input  logic [3:0]  q,
    output logic [1:0]  c,
    output logic [3:0]  data_in,
    output logic        carry_msb,
    output logic        carry_lsb
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             dir_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] amt_r;
    logic [3:0]       val_r;
    logic [CNT_W-1:0] rem_r;

    // State register plus latched command fields.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            dir_r  <= 1'b0;
            mode_r <= 2'b00;
            amt_r  <= '0;
            val_r  <= 4'b0000;
            rem_r  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.start) begin
                dir_r  <= bus.dir;
                mode_r <= bus.mode;
                amt_r  <= bus.amount;
                val_r  <= bus.load_val;
            end
            // Counter is armed in LOAD so it reads amount on the first SHIFT
            // cycle; it returns to 0 as SHIFT exits on the count of 1.
            unique case (state)
                LOAD:    rem_r <= amt_r;
                SHIFT:   rem_r <= rem_r - 1'b1;
                default: rem_r <= '0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.start) state_nxt = LOAD;
            LOAD:  state_nxt = (amt_r != '0) ? SHIFT : DONE;
            SHIFT: if (rem_r == CNT_W'(1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs; carries additionally look at live q during SHIFT.
    always_comb begin
        c             = 2'b00;
        data_in       = 4'b0000;
        carry_msb     = 1'b0;
        carry_lsb     = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.remaining = '0;
        unique case (state)
            LOAD: begin
                c        = 2'b11;
                data_in  = val_r;
                bus.busy = 1'b1;
            end
            SHIFT: begin
                c             = dir_r ? 2'b10 : 2'b01;
                bus.busy      = 1'b1;
                bus.remaining = rem_r;
                if (!dir_r) begin
                    unique case (mode_r)
                        2'b00: carry_msb = 1'b0;
                        2'b01: carry_msb = 1'b1;
                        2'b10: carry_msb = q[0];
                        2'b11: carry_msb = q[3];
                        default: carry_msb = 1'b0;
                    endcase
                end else begin
                    // Arithmetic left is plain zero fill.
                    unique case (mode_r)
                        2'b00: carry_lsb = 1'b0;
                        2'b01: carry_lsb = 1'b1;
                        2'b10: carry_lsb = q[3];
                        2'b11: carry_lsb = 1'b0;
                        default: carry_lsb = 1'b0;
                    endcase
                end
            end
            DONE: bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule
